wasm_operand_stack: RTL

- Parametrised operand stack for the WebAssembly CPU: holds values of configurable width and depth.
- Supports a combined pop-0..2 / push-0..1 per operation, which covers every unary, binary and test instruction (e.g. i32.eqz: pop 1, push 1).
- Supports a multi-cycle branch unwind that discards intermediate values while preserving block results.
- Drives the CPU's `result` / `result_empty` / `trap` outputs directly, replacing the fixed single-depth result register.

---
 rtl/wasm_operand_stack_if.sv | 42 ++++
 rtl/wasm_operand_stack.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wasm_operand_stack_if.sv
// rtl/wasm_operand_stack_if.sv - CPU <-> operand stack request/status bundle
//
// Purpose: groups the operand stack request and status signals.
//   master : CPU side, drives requests and observes stack status.
//   slave  : operand stack side, accepts requests and drives status.
// Signals:
//   op_valid, pop_count[1:0], push, push_data[WIDTH-1:0]  pop/push request
//   unwind_valid, unwind_base[AW:0], unwind_keep[AW:0]    branch unwind request
//   busy, count[AW:0], tos0, tos1, result, result_empty,
//   trap[2:0]                                             stack status
interface wasm_operand_stack_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic             op_valid;
  logic [1:0]       pop_count;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             unwind_valid;
  logic [AW:0]      unwind_base;
  logic [AW:0]      unwind_keep;
  logic             busy;
  logic [AW:0]      count;
  logic [WIDTH-1:0] tos0;
  logic [WIDTH-1:0] tos1;
  logic [WIDTH-1:0] result;
  logic             result_empty;
  logic [2:0]       trap;

  modport master (
    output op_valid, pop_count, push, push_data,
    output unwind_valid, unwind_base, unwind_keep,
    input  busy, count, tos0, tos1, result, result_empty, trap
  );

  modport slave (
    input  op_valid, pop_count, push, push_data,
    input  unwind_valid, unwind_base, unwind_keep,
    output busy, count, tos0, tos1, result, result_empty, trap
  );
endinterface

// File: rtl/wasm_operand_stack.sv
// rtl/wasm_operand_stack.sv - WebAssembly operand stack with branch unwind
//
// Purpose: register-array operand stack. Each operation pops 0..2 values and
// optionally pushes one; a branch unwind copies the top unwind_keep values
// down to unwind_base one value per cycle. Faults latch a sticky trap code.
// Ports:
//   clk    in  single clock
//   reset  in  synchronous, active-high
//   s      wasm_operand_stack_if.slave (requests in, status out)
// Trap codes: 0 none, 1 underflow, 2 overflow, 3 illegal request,
//             4 request while busy.
module wasm_operand_stack #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic                clk,
  input logic                reset,
  wasm_operand_stack_if.slave s
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UNWIND,
    ST_TRAPPED
  } state_t;

  localparam logic [AW+1:0] LP_DEPTH_X = (AW+2)'(DEPTH);
  localparam logic [AW:0]   LP_ONE     = (AW+1)'(1);
  localparam logic [AW:0]   LP_TWO     = (AW+1)'(2);
  localparam logic [AW-1:0] LP_ONE_A   = AW'(1);

  localparam logic [2:0] TRAP_UNDER   = 3'd1;
  localparam logic [2:0] TRAP_OVER    = 3'd2;
  localparam logic [2:0] TRAP_ILLEGAL = 3'd3;
  localparam logic [2:0] TRAP_BUSY    = 3'd4;

  state_t           r_state, w_state_nxt;
  logic [AW:0]      r_count, w_count_nxt;
  logic [2:0]       r_trap, w_trap_nxt;
  logic [AW-1:0]    r_src, w_src_nxt;
  logic [AW-1:0]    r_dst, w_dst_nxt;
  logic [AW:0]      r_n, w_n_nxt;
  logic [AW:0]      r_target, w_target_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;

  // Height arithmetic is one bit wider than count so push-on-full and
  // base+keep sums cannot wrap around.
  logic [AW+1:0] w_cnt_x, w_pop_x, w_after, w_uw_sum;
  assign w_cnt_x  = {1'b0, r_count};
  assign w_pop_x  = {{AW{1'b0}}, s.pop_count};
  assign w_after  = w_cnt_x - w_pop_x + {{(AW+1){1'b0}}, s.push};
  assign w_uw_sum = {1'b0, s.unwind_base} + {1'b0, s.unwind_keep};

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_trap_nxt   = r_trap;
    w_src_nxt    = r_src;
    w_dst_nxt    = r_dst;
    w_n_nxt      = r_n;
    w_target_nxt = r_target;
    w_we         = 1'b0;
    w_waddr      = r_dst;
    w_wdata      = r_mem[r_src];

    case (r_state)
      ST_IDLE: begin
        if (s.op_valid && s.unwind_valid) begin
          w_trap_nxt  = TRAP_ILLEGAL;
          w_state_nxt = ST_TRAPPED;
        end else if (s.op_valid) begin
          if (s.pop_count == 2'd3) begin
            w_trap_nxt  = TRAP_ILLEGAL;
            w_state_nxt = ST_TRAPPED;
          end else if (w_pop_x > w_cnt_x) begin
            w_trap_nxt  = TRAP_UNDER;
            w_state_nxt = ST_TRAPPED;
          end else if (w_after > LP_DEPTH_X) begin
            w_trap_nxt  = TRAP_OVER;
            w_state_nxt = ST_TRAPPED;
          end else begin
            // The pushed value lands in the slot just above the remaining
            // values, i.e. it replaces the first popped operand.
            w_we        = s.push;
            w_waddr     = AW'(r_count - {{(AW-1){1'b0}}, s.pop_count});
            w_wdata     = s.push_data;
            w_count_nxt = (AW+1)'(w_after);
          end
        end else if (s.unwind_valid) begin
          if (w_uw_sum > w_cnt_x) begin
            w_trap_nxt  = TRAP_UNDER;
            w_state_nxt = ST_TRAPPED;
          end else if (s.unwind_keep == '0) begin
            w_count_nxt = s.unwind_base;
          end else begin
            w_src_nxt    = AW'(r_count - s.unwind_keep);
            w_dst_nxt    = AW'(s.unwind_base);
            w_n_nxt      = s.unwind_keep;
            w_target_nxt = (AW+1)'(w_uw_sum);
            w_state_nxt  = ST_UNWIND;
          end
        end
      end

      ST_UNWIND: begin
        if (s.op_valid || s.unwind_valid) begin
          // Abandon the unwind; count still holds the pre-unwind height.
          w_trap_nxt  = TRAP_BUSY;
          w_state_nxt = ST_TRAPPED;
        end else begin
          // Copy even when src==dst so the unwind always takes keep cycles.
          w_we      = 1'b1;
          w_src_nxt = r_src + LP_ONE_A;
          w_dst_nxt = r_dst + LP_ONE_A;
          w_n_nxt   = r_n - LP_ONE;
          if (r_n == LP_ONE) begin
            w_count_nxt = r_target;
            w_state_nxt = ST_IDLE;
          end
        end
      end

      ST_TRAPPED: begin
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_trap   <= '0;
      r_src    <= '0;
      r_dst    <= '0;
      r_n      <= '0;
      r_target <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_trap   <= w_trap_nxt;
      r_src    <= w_src_nxt;
      r_dst    <= w_dst_nxt;
      r_n      <= w_n_nxt;
      r_target <= w_target_nxt;
    end
  end

  // Storage is deliberately not reset; slots above count are unobservable.
  always_ff @(posedge clk) begin
    if (w_we && !reset) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  logic [AW-1:0]    w_idx0, w_idx1;
  logic [WIDTH-1:0] w_tos0, w_tos1;
  assign w_idx0 = AW'(r_count - LP_ONE);
  assign w_idx1 = AW'(r_count - LP_TWO);
  assign w_tos0 = (r_count == '0)    ? '0 : r_mem[w_idx0];
  assign w_tos1 = (r_count < LP_TWO) ? '0 : r_mem[w_idx1];

  assign s.busy         = (r_state == ST_UNWIND);
  assign s.count        = r_count;
  assign s.tos0         = w_tos0;
  assign s.tos1         = w_tos1;
  assign s.result       = w_tos0;
  assign s.result_empty = (r_count == '0);
  assign s.trap         = r_trap;

endmodule
